// File: rtl/mpe_pkg.sv
// Shared constants and FSM encoding for the matrix-PE feeder.
package mpe_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 512;
    localparam int UW_DEF     = 8;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } mpe_state_t;

endpackage

// File: rtl/mpe_stream_lane.sv
// One SRAM-to-PE lane: address/remaining counters, 1-cycle read tracking,
// 2-entry skid FIFO and the valid/ready output port.
module mpe_stream_lane
    import mpe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int UW = UW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_base,
    input  logic [UW-1:0] load_cnt,
    input  logic          run,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          idle
);

    logic [AW-1:0] addr;
    logic [UW-1:0] remaining;
    logic          inflight;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic          rptr;
    logic          wptr;
    logic [1:0]    occ;
    logic          push;
    logic          pop;
    logic [2:0]    pending;

    assign push      = inflight;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rptr];
    assign rd_addr   = addr;
    assign idle      = (remaining == '0) && !inflight && (occ == 2'd0);

    // Credit counts the beat leaving this cycle so a full-rate stream never bubbles.
    assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en   = run && (remaining != '0) && (pending < 3'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            rptr      <= 1'b0;
            wptr      <= 1'b0;
            occ       <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (load) begin
                addr      <= load_base;
                remaining <= load_cnt;
            end else if (rd_en) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            inflight <= rd_en;
            if (push) begin
                mem[wptr] <= rd_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mpe_feeder.sv
// Source-side sequencer for matrix_pe: accepts a command, issues the uop,
// then streams neuron and weight lines from NRAM/WRAM through two lanes.
module mpe_feeder
    import mpe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int UW = UW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [UW-1:0] cmd_uop,
    input  logic [AW-1:0] cmd_nram_base,
    input  logic [AW-1:0] cmd_wram_base,
    output logic          nram_rd_en,
    output logic [AW-1:0] nram_rd_addr,
    input  logic [DW-1:0] nram_rd_data,
    output logic          wram_rd_en,
    output logic [AW-1:0] wram_rd_addr,
    input  logic [DW-1:0] wram_rd_data,
    output logic [UW-1:0] ib_ctl_uop,
    output logic          ib_ctl_uop_valid,
    input  logic          ib_ctl_uop_ready,
    output logic [DW-1:0] nram_mpe_neuron,
    output logic          nram_mpe_neuron_valid,
    input  logic          nram_mpe_neuron_ready,
    output logic [DW-1:0] wram_mpe_weight,
    output logic          wram_mpe_weight_valid,
    input  logic          wram_mpe_weight_ready,
    output logic          busy,
    output logic          done
);

    mpe_state_t    state;
    logic [UW-1:0] uop_q;
    logic          cmd_fire;
    logic          run;
    logic          nram_idle;
    logic          wram_idle;

    assign cmd_ready        = (state == ST_IDLE);
    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
    assign ib_ctl_uop_valid = (state == ST_ISSUE);
    assign ib_ctl_uop       = uop_q;
    assign cmd_fire         = cmd_valid && cmd_ready;
    // Lanes only read once the uop has been handed over.
    assign run              = (state == ST_STREAM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            uop_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        uop_q <= cmd_uop;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ib_ctl_uop_ready) begin
                        state <= (uop_q == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (nram_idle && wram_idle) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mpe_stream_lane #(.AW(AW), .DW(DW), .UW(UW)) u_nram_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cmd_fire),
        .load_base (cmd_nram_base),
        .load_cnt  (cmd_uop),
        .run       (run),
        .rd_en     (nram_rd_en),
        .rd_addr   (nram_rd_addr),
        .rd_data   (nram_rd_data),
        .out_data  (nram_mpe_neuron),
        .out_valid (nram_mpe_neuron_valid),
        .out_ready (nram_mpe_neuron_ready),
        .idle      (nram_idle)
    );

    mpe_stream_lane #(.AW(AW), .DW(DW), .UW(UW)) u_wram_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cmd_fire),
        .load_base (cmd_wram_base),
        .load_cnt  (cmd_uop),
        .run       (run),
        .rd_en     (wram_rd_en),
        .rd_addr   (wram_rd_addr),
        .rd_data   (wram_rd_data),
        .out_data  (wram_mpe_weight),
        .out_valid (wram_mpe_weight_valid),
        .out_ready (wram_mpe_weight_ready),
        .idle      (wram_idle)
    );

endmodule
